// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and helpers for the segment display arbiter
package seg_pkg;

  localparam int NCH   = 3;
  localparam int SEG_W = 20;
  localparam int PT_W  = 6;
  localparam logic [SEG_W-1:0] SEG_MAX = 20'd999999;

  localparam int CH_SCORE = 0;
  localparam int CH_BEST  = 1;
  localparam int CH_ALERT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_FREE  = 2'd2
  } arb_state_e;

  // One-hot of the highest-numbered (highest-priority) set request.
  function automatic logic [NCH-1:0] prio_pick(input logic [NCH-1:0] r);
    prio_pick = '0;
    for (int n = 0; n < NCH; n++) begin
      if (r[n]) begin
        prio_pick    = '0;
        prio_pick[n] = 1'b1;
      end
    end
  endfunction

  // Channels strictly above the one-hot grant g; zero when g is zero.
  function automatic logic [NCH-1:0] above_mask(input logic [NCH-1:0] g);
    logic seen;
    above_mask = '0;
    seen       = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      above_mask[n] = seen;
      if (g[n]) seen = 1'b1;
    end
  endfunction

  function automatic logic [SEG_W-1:0] sat_seg(input logic [SEG_W-1:0] v);
    sat_seg = (v > SEG_MAX) ? SEG_MAX : v;
  endfunction

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// rtl/seg_disp_arbiter_if.sv - requester/driver bundle around the display arbiter
interface seg_disp_arbiter_if;
  import seg_pkg::*;

  logic [NCH-1:0]       req;
  logic [NCH*SEG_W-1:0] ch_data;
  logic [NCH*PT_W-1:0]  ch_point;
  logic [NCH-1:0]       ch_sign;
  logic [SEG_W-1:0]     data;
  logic [PT_W-1:0]      point;
  logic                 en;
  logic                 sign;
  logic [NCH-1:0]       grant;

  modport master (
    output req, ch_data, ch_point, ch_sign,
    input  data, point, en, sign, grant
  );

  modport slave (
    input  req, ch_data, ch_point, ch_sign,
    output data, point, en, sign, grant
  );

endinterface

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running divider producing a one-cycle pulse every TICK_DIV clocks
module ms_tick_gen #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = (tick_cnt_q == LAST) ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  assign ms_tick = (tick_cnt_q == LAST);

endmodule

// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - fixed-priority sharing of the 6-digit display with dwell and blink
module seg_disp_arbiter import seg_pkg::*; #(
  parameter int             TICK_DIV = 50_000,
  parameter int             DWELL_MS = 500,
  parameter int             BLINK_MS = 250,
  parameter logic [NCH-1:0] BLINK_EN = 3'b100
) (
  input logic              clk,
  input logic              rst_n,
  seg_disp_arbiter_if.slave bus
);

  localparam int DW_W = $clog2(DWELL_MS) + 1;
  localparam int BL_W = $clog2(BLINK_MS) + 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_MS - 1);
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_MS - 1);

  arb_state_e       state_q, state_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic [NCH-1:0]   top_req, above_req;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [BL_W-1:0]  blink_q, blink_d;
  logic             phase_q, phase_d;
  logic [SEG_W-1:0] data_q, data_d;
  logic [PT_W-1:0]  point_q, point_d;
  logic             sign_q, sign_d;
  logic             en_q, en_d;
  logic             ms_tick;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .ms_tick (ms_tick)
  );

  always_comb begin : fsm_next
    state_d   = state_q;
    grant_d   = grant_q;
    dwell_d   = dwell_q;
    top_req   = prio_pick(bus.req);
    above_req = bus.req & above_mask(grant_q);
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_DWELL;
          grant_d = top_req;
          dwell_d = '0;
        end
      end
      ST_DWELL: begin
        // Preemption is checked first so it wins over an expiring dwell.
        if (|above_req) begin
          grant_d = top_req;
          dwell_d = '0;
        end else if (ms_tick) begin
          dwell_d = dwell_q + 1'b1;
          if (dwell_q == DWELL_LAST) state_d = ST_FREE;
        end
      end
      ST_FREE: begin
        if ((|above_req) || !(|(bus.req & grant_q))) begin
          if (|bus.req) begin
            state_d = ST_DWELL;
            grant_d = top_req;
            dwell_d = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        dwell_d = '0;
      end
    endcase
  end

  // Values freeze while the granted requester is dropped but still held by dwell.
  always_comb begin : datapath_next
    data_d  = data_q;
    point_d = point_q;
    sign_d  = sign_q;
    if (state_d != ST_IDLE) begin
      for (int n = 0; n < NCH; n++) begin
        if (grant_d[n] && bus.req[n]) begin
          data_d  = sat_seg(bus.ch_data[n*SEG_W +: SEG_W]);
          point_d = bus.ch_point[n*PT_W +: PT_W];
          sign_d  = bus.ch_sign[n];
        end
      end
    end
  end

  always_comb begin : blink_next
    blink_d = blink_q;
    phase_d = phase_q;
    if (state_d == ST_IDLE) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (grant_d != grant_q) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (ms_tick) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
    en_d = (state_d != ST_IDLE) && ((|(grant_d & BLINK_EN)) ? phase_d : 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      dwell_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      data_q  <= '0;
      point_q <= '0;
      sign_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dwell_q <= dwell_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      point_q <= point_d;
      sign_q  <= sign_d;
      en_q    <= en_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.data  = data_q;
  assign bus.point = point_q;
  assign bus.sign  = sign_q;
  assign bus.en    = en_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - directed and randomized checks of seg_disp_arbiter against a reference model
module tb_seg_disp_arbiter;

  localparam int         TB_TICK  = 4;
  localparam int         TB_DWELL = 3;
  localparam int         TB_BLINK = 2;
  localparam logic [2:0] TB_BEN   = 3'b100;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_disp_arbiter_if bus();

  seg_disp_arbiter #(
    .TICK_DIV (TB_TICK),
    .DWELL_MS (TB_DWELL),
    .BLINK_MS (TB_BLINK),
    .BLINK_EN (TB_BEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [19:0] cd [3];
  logic [5:0]  cp [3];
  logic [2:0]  cs;

  // Model: owner channel, ms ticks seen since that grant, displayed values.
  int          e;
  int          cur;
  int          gt;
  logic [19:0] m_data;
  logic [5:0]  m_point;
  logic        m_sign;

  task automatic drive(input logic [2:0] r);
    bus.req      = r;
    bus.ch_data  = {cd[2], cd[1], cd[0]};
    bus.ch_point = {cp[2], cp[1], cp[0]};
    bus.ch_sign  = cs;
  endtask

  task automatic model_reset();
    e = 0; cur = -1; gt = 0;
    m_data = '0; m_point = '0; m_sign = 1'b0;
  endtask

  task automatic model_step();
    int   top;
    logic tick;
    e++;
    tick = (e % TB_TICK) == 0;
    top = -1;
    for (int n = 0; n < 3; n++) if (bus.req[n]) top = n;
    if (cur < 0) begin
      if (top >= 0) begin cur = top; gt = 0; end
    end else if (gt < TB_DWELL) begin
      if (top > cur) begin cur = top; gt = 0; end
      else if (tick) gt++;
    end else if (top != cur) begin
      if (top < 0) cur = -1;
      else begin cur = top; gt = 0; end
    end else if (tick) begin
      gt++;
    end
    if (cur >= 0 && bus.req[cur]) begin
      m_data  = (cd[cur] > 20'd999999) ? 20'd999999 : cd[cur];
      m_point = cp[cur];
      m_sign  = cs[cur];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] eg;
    logic       een;
    eg  = (cur < 0) ? 3'b000 : 3'(1 << cur);
    een = (cur < 0) ? 1'b0 : (TB_BEN[cur] ? ((gt / TB_BLINK) % 2 == 0) : 1'b1);
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("data",  32'(bus.data),  32'(m_data));
    chk("point", 32'(bus.point), 32'(m_point));
    chk("en",    32'(bus.en),    32'(een));
    chk("sign",  32'(bus.sign),  32'(m_sign));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_data"},  32'(bus.data),  32'd0);
    chk({tag, "_point"}, 32'(bus.point), 32'd0);
    chk({tag, "_en"},    32'(bus.en),    32'd0);
    chk({tag, "_sign"},  32'(bus.sign),  32'd0);
  endtask

  initial begin
    logic [2:0] r;
    int         k;
    for (int n = 0; n < 3; n++) begin cd[n] = '0; cp[n] = '0; end
    cs = '0;
    rst_n = 1'b0;
    drive(3'b000);
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Single request, next edge shows it.
    cd[0] = 20'd1234;
    drive(3'b001);
    cycle();
    chk("s1_grant", 32'(bus.grant), 32'd1);
    chk("s1_data",  32'(bus.data),  32'd1234);
    chk("s1_en",    32'(bus.en),    32'd1);
    chk("s1_sign",  32'(bus.sign),  32'd0);

    // Higher request preempts; its early drop is held off by dwell.
    cd[1] = 20'd777; cp[1] = 6'b010000; cs[1] = 1'b1;
    repeat (4) cycle();
    drive(3'b011);
    cycle();
    chk("s2_preempt", 32'(bus.grant), 32'd2);
    repeat (4) cycle();
    drive(3'b001);
    for (int i = 0; i < 40 && bus.grant !== 3'b001; i++) cycle();
    chk("s2_return", 32'(bus.grant), 32'd1);

    // Alert preempts ch1 mid-dwell and blinks.
    drive(3'b011);
    repeat (3) cycle();
    cd[2] = 20'd42; cs[2] = 1'b1;
    drive(3'b111);
    cycle();
    chk("s3_preempt", 32'(bus.grant), 32'd4);
    chk("s3_en_first", 32'(bus.en), 32'd1);
    repeat (30) cycle();

    // Saturation and point pass-through.
    cd[0] = 20'd1_000_500; cp[0] = 6'b000100;
    drive(3'b001);
    for (int i = 0; i < 40 && bus.grant !== 3'b001; i++) cycle();
    chk("s4_grant", 32'(bus.grant), 32'd1);
    chk("s4_sat",   32'(bus.data),  32'd999999);
    chk("s4_point", 32'(bus.point), 32'd4);

    // Asynchronous reset mid-dwell.
    cycle();
    rst_n = 1'b0;
    #1;
    check_zero("s5_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b001);
    cycle();
    chk("s5_regrant", 32'(bus.grant), 32'd1);

    // Everything drops in FREE: idle, blanked, data held.
    repeat (20) cycle();
    drive(3'b000);
    cycle();
    chk("s6_grant", 32'(bus.grant), 32'd0);
    chk("s6_en",    32'(bus.en),    32'd0);
    chk("s6_hold",  32'(bus.data),  32'd999999);
    cd[0] = 20'd5;
    drive(3'b000);
    cycle();
    chk("s6_hold2", 32'(bus.data), 32'd999999);

    // Randomized traffic against the model.
    r = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(0, 2));
        cd[k] = 20'($urandom_range(0, 20'hFFFFF));
        cp[k] = 6'($urandom_range(0, 63));
        cs[k] = 1'($urandom_range(0, 1));
      end
      drive(r);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
